// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: blank pattern, hex segment table, digit count.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g patterns, entry 0 at the right (index == nibble value).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int calc_tick(input int clkspeed, input int refresh_hz);
        int t;
        t = clkspeed / (refresh_hz * 64);
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned commit and duty-cycle dimming.
// Optional SEVEN_SEG_BLANK_LEADING_ZEROS_EN darkens leading zero digits 3..1.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLKSPEED   = 50000000,
    parameter int REFRESH_HZ = 1000,
    parameter int DUTY_CYCLE = 7
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dig_en,
    output logic        busy,
    output logic        frame_sync,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int TICK = calc_tick(CLKSPEED, REFRESH_HZ);
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] TICK_M1 = PW'(TICK - 1);
    localparam logic [3:0]    DUTY    = 4'(DUTY_CYCLE);

    logic [PW-1:0] presc;
    logic [3:0]    sub;
    logic [1:0]    dig;
    logic [15:0]   display, pending, disp_next;
    logic          tick, wrap, lit, lz_dark;
    logic [3:0]    cur_nib;
    logic [6:0]    seg_dec;

    assign tick = (presc == TICK_M1);
    assign wrap = tick && (sub == 4'hF) && (dig == 2'd3);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            presc      <= '0;
            sub        <= '0;
            dig        <= '0;
            frame_sync <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_sync <= wrap;
            if (tick) begin
                sub <= sub + 1'b1;
                if (sub == 4'hF)
                    dig <= dig + 1'b1;
            end
        end
    end

    // The frame_sync cycle is the commit cycle; a write landing on it bypasses pending.
    always_comb begin
        disp_next = display;
        if (frame_sync)
            disp_next = wr_en ? wr_data : pending;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            display <= '0;
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            display <= disp_next;
            if (wr_en)
                pending <= wr_data;
            if (frame_sync)
                busy <= 1'b0;
            else if (wr_en)
                busy <= 1'b1;
        end
    end

    assign cur_nib = disp_next[{dig, 2'b00} +: 4];

`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
    always_comb begin
        lz_dark = 1'b0;
        case (dig)
            2'd3:    lz_dark = (disp_next[15:12] == 4'h0);
            2'd2:    lz_dark = (disp_next[15:8]  == 8'h00);
            2'd1:    lz_dark = (disp_next[15:4]  == 12'h000);
            default: lz_dark = 1'b0;
        endcase
    end
`else
    assign lz_dark = 1'b0;
`endif

    hex_to_seg u_dec (
        .nib (cur_nib),
        .seg (seg_dec)
    );

    assign lit = (sub < DUTY) && dig_en[dig] && !lz_dark;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
        end else begin
            an  <= lit ? ~(4'b0001 << dig) : 4'hF;
            seg <= lit ? seg_dec : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised frame-level scoreboard bench for seven_seg_scanner (TICK=2, 128-cycle frames).
module tb_seven_seg_scanner;

    localparam int T     = 2;
    localparam int DUTY  = 7;
    localparam int FRAME = 4 * 16 * T;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  dig_en = 4'hF;
    logic        busy, frame_sync;
    logic [6:0]  seg;
    logic [3:0]  an;

    seven_seg_scanner #(
        .CLKSPEED   (12800),
        .REFRESH_HZ (100),
        .DUTY_CYCLE (DUTY)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .dig_en     (dig_en),
        .busy       (busy),
        .frame_sync (frame_sync),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  en;
    } frame_t;

    frame_t      sbq[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_stop = 0;
    int          win = 0;
    logic [15:0] pend = '0;
    bit          had_mid = 0;

    logic [6:0] ref_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lit(input frame_t f, input int i);
        bit vis;
        vis = f.en[i];
`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
        if (i > 0 && (f.val >> (4 * i)) == 16'h0)
            vis = 0;
`endif
        return vis ? DUTY * T : 0;
    endfunction

    // Monitor: one window of FRAME pin samples per frame_sync, checked against the queued frame.
    initial begin
        frame_t cur;
        int     lit[4];
        int     bad;
        bit     hit;
        cur = '{16'h0, 4'h0};
        bad = 0;
        foreach (lit[i]) lit[i] = 0;
        forever begin
            @(negedge clk);
            if (win > 0) begin
                if (win == FRAME) begin
                    foreach (lit[i]) lit[i] = 0;
                    bad = 0;
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: got empty queue, expected a frame entry");
                    end else
                        cur = sbq.pop_front();
                end
                hit = 0;
                for (int i = 0; i < 4; i++) begin
                    if (an == (4'hF ^ (4'b0001 << i))) begin
                        hit = 1;
                        if (seg == ref_tbl[cur.val[4*i +: 4]]) lit[i]++;
                        else bad++;
                    end
                end
                if (!hit && !(an == 4'hF && seg == 7'h7F)) bad++;
                win--;
                if (win == 0) begin
                    for (int i = 0; i < 4; i++)
                        check($sformatf("lit_cycles val=%04h en=%h dig%0d", cur.val, cur.en, i),
                              lit[i], exp_lit(cur, i));
                    check($sformatf("bad_pins val=%04h", cur.val), bad, 0);
                end
            end
            if (frame_sync && !mon_stop)
                win = FRAME;
        end
    end

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_sync && n < FRAME + 8);
        if (!frame_sync) begin
            $display("FAIL frame_sync_timeout: got no pulse in %0d cycles, expected one", n);
            $fatal(1, "frame_sync timeout");
        end
    endtask

    task automatic do_write(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        pend    = d;
        @(negedge clk);
        wr_en = 1'b0;
        check("busy_after_write", busy, 1);
    endtask

    // mode: 0 none, 1 one mid-frame write, 2 two mid-frame writes, 3 write on commit cycle
    task automatic run_frame(input int mode, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [3:0] en);
        wait_fs();
        check("busy_at_commit", busy, had_mid);
        dig_en = en;
        if (mode == 3) begin
            wr_en   = 1'b1;
            wr_data = d0;
            pend    = d0;
        end
        sbq.push_back('{pend, en});
        @(negedge clk);
        wr_en = 1'b0;
        check("busy_after_commit", busy, 0);
        had_mid = 0;
        if (mode == 1 || mode == 2) begin
            repeat ($urandom_range(4, 50)) @(negedge clk);
            do_write(d0);
            had_mid = 1;
        end
        if (mode == 2) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            do_write(d1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        repeat (3) @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_busy", busy, 0);
        check("reset_fs", frame_sync, 0);
        reset_b = 1'b1;
        @(negedge clk);
        check("first_an", an, 4'hE);
        check("first_seg", seg, 7'h40);

        run_frame(1, 16'h1F80, 16'h0, 4'hF);
        run_frame(2, 16'h1111, 16'h2222, 4'hF);
        run_frame(0, 16'h0, 16'h0, 4'hF);
        run_frame(3, 16'hABCD, 16'h0, 4'hF);
        run_frame(1, 16'h8888, 16'h0, 4'hF);
        run_frame(1, 16'h0050, 16'h0, 4'b0101);
        run_frame(0, 16'h0, 16'h0, 4'hF);
        for (int f = 0; f < 14; f++)
            run_frame($urandom_range(0, 3),
                      16'($urandom) & masks[$urandom_range(0, 3)],
                      16'($urandom) & masks[$urandom_range(0, 3)],
                      ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF);
        mon_stop = 1;
        wait_fs();
        repeat (2) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        check("window_closed", win, 0);

        // Reset mid-frame: immediate blank, pending write discarded.
        repeat (40) @(negedge clk);
        dig_en = 4'hF;
        wr_en = 1'b1;
        wr_data = 16'h1234;
        @(negedge clk);
        wr_en = 1'b0;
        reset_b = 1'b0;
        #1;
        check("midreset_an", an, 4'hF);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_busy", busy, 0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check("postreset_an", an, 4'hE);
        check("postreset_seg", seg, 7'h40);
        wait_fs();
        check("postreset_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("postreset_frame_an", an, 4'hE);
        check("postreset_frame_seg", seg, 7'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
